// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the Rs1/Rs2 sensors,
// classifies each insertion, queues accepted coins in a small FIFO and
// hands them downstream as single-cycle coin codes separated by idle cycles.
module coin_acceptor #(
    parameter int DEBOUNCE   = 3,
    parameter int JAM_CYCLES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sens_1,
    input  logic                          sens_2,
    input  logic                          accept_en,
    output logic [1:0]                    coin,
    output logic                          reject,
    output logic                          jam,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int CNT_MAX = (JAM_CYCLES > DEBOUNCE) ? JAM_CYCLES : DEBOUNCE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RELEASE, JAM} state_t;

    // Saturating increment: the debounce/jam counter must never wrap back to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(CNT_MAX)) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       s1_sync_q, s2_sync_q;
    logic [1:0]       p;
    state_t           state_q, state_d;
    logic [1:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             classify;

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [1:0]       coin_q, coin_d;
    logic             reject_q, reject_d, jam_q;
    logic             full, pop, push_req, push;

    // Sensor pattern as seen after the two-flop synchronisers; bit1 = Rs2, bit0 = Rs1.
    assign p       = {s2_sync_q[1], s1_sync_q[1]};
    assign cnt_inc = sat_inc(cnt_q);

    assign coin    = coin_q;
    assign reject  = reject_q;
    assign jam     = jam_q;
    assign pending = occ_q;

    // Two-flop synchronisers for the asynchronous slot sensors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sync_q <= 2'b00;
            s2_sync_q <= 2'b00;
        end else begin
            s1_sync_q <= {s1_sync_q[0], sens_1};
            s2_sync_q <= {s2_sync_q[0], sens_2};
        end
    end

    // Insertion FSM: debounce a stable pattern, classify once, then watch for a stuck sensor.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        classify = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p != 2'b00) begin
                    state_d = SETTLE;
                    pat_d   = p;
                    cnt_d   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (p == 2'b00) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (p != pat_q) begin
                    pat_d = p;
                    cnt_d = CNT_W'(1);
                end else if (cnt_inc >= CNT_W'(DEBOUNCE)) begin
                    classify = 1'b1;
                    state_d  = RELEASE;
                    // Restart so the jam window counts clocks after acceptance.
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (p == 2'b00) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_W'(JAM_CYCLES)) begin
                        state_d = JAM;
                    end
                end
            end
            JAM: begin
                if (p == 2'b00) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, latched pattern and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue control: pop frees a slot on the same edge, so a full queue still takes a push.
    always_comb begin
        push_req = classify && (pat_q != 2'b11);
        full     = (occ_q == OCC_W'(FIFO_DEPTH));
        pop      = accept_en && (occ_q != '0) && (coin_q == 2'd0);
        push     = push_req && (!full || pop);
        reject_d = classify && ((pat_q == 2'b11) || (push_req && !push));
        // The pattern code 01/10 is already the downstream coin code 1/2.
        coin_d   = pop ? mem_q[rd_ptr_q] : 2'd0;
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Queue pointers, occupancy and the registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            coin_q   <= 2'd0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q    <= occ_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            jam_q    <= (state_d == JAM);
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pat_q;
    end

endmodule
